// File: rtl/brent_kung_16bit.sv
// Registered 16-bit adder with carry-in/carry-out.
// Carries come from a Brent-Kung prefix tree (up-sweep + down-sweep).
module brent_kung_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        Cin,
  input  logic        in_valid,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        out_valid
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [15:0] s;
  logic        g0;

  logic [7:0]  g1;
  logic [7:1]  p1;
  logic [3:0]  g2;
  logic [3:1]  p2;
  logic [1:0]  g3;
  logic        p3;
  logic        g4;

  logic d2, d4, d5, d6, d8, d9;
  logic d10, d11, d12, d13, d14;

  assign p  = a ^ b;
  assign g  = a & b;
  assign g0 = g[0] | (p[0] & Cin);

  // Groups rooted at bit 0 only ever need G
  assign g1[0] = g[1] | (p[1] & g0);

  for (genvar k = 1; k < 8; k++) begin : gen_l1
    assign g1[k] = g[2*k+1] | (p[2*k+1] & g[2*k]);
    assign p1[k] = p[2*k+1] & p[2*k];
  end

  assign g2[0] = g1[1] | (p1[1] & g1[0]);

  for (genvar k = 1; k < 4; k++) begin : gen_l2
    assign g2[k] = g1[2*k+1] | (p1[2*k+1] & g1[2*k]);
    assign p2[k] = p1[2*k+1] & p1[2*k];
  end

  assign g3[0] = g2[1] | (p2[1] & g2[0]);
  assign g3[1] = g2[3] | (p2[3] & g2[2]);
  assign p3    = p2[3] & p2[2];
  assign g4    = g3[1] | (p3 & g3[0]);

  assign d11 = g2[2] | (p2[2] & g3[0]);

  assign d5  = g1[2] | (p1[2] & g2[0]);
  assign d9  = g1[4] | (p1[4] & g3[0]);
  assign d13 = g1[6] | (p1[6] & d11);

  assign d2  = g[2]  | (p[2]  & g1[0]);
  assign d4  = g[4]  | (p[4]  & g2[0]);
  assign d6  = g[6]  | (p[6]  & d5);
  assign d8  = g[8]  | (p[8]  & g3[0]);
  assign d10 = g[10] | (p[10] & d9);
  assign d12 = g[12] | (p[12] & d11);
  assign d14 = g[14] | (p[14] & d13);

  assign c = {d14, d13, d12, d11,
              d10, d9,  d8,  g3[0],
              d6,  d5,  d4,  g2[0],
              d2,  g1[0], g0, Cin};

  assign s = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= 16'h0000;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= g4;
      end
    end
  end

endmodule

// File: tb/tb_brent_kung_16bit.sv
// Self-checking bench for brent_kung_16bit.
// Reference: plain 17-bit integer add tracked per clock edge.
module tb_brent_kung_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        Cin;
  logic        in_valid;
  logic [15:0] Sum;
  logic        Cout;
  logic        out_valid;

  int errors;
  int checks;

  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_v;

  brent_kung_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic tv);
    logic [16:0] r;
    a        = ta;
    b        = tb;
    Cin      = tc;
    in_valid = tv;
    r = {1'b0, ta} + {1'b0, tb} + {16'h0000, tc};
    @(posedge clk);
    #1;
    exp_v = tv;
    if (tv) begin
      exp_sum  = r[15:0];
      exp_cout = r[16];
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    a        = 16'hA5A5;
    b        = 16'h5A5A;
    Cin      = 1'b1;
    in_valid = 1'b1;
    #2;
    checks++;
    if (Sum !== 16'h0000 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got sum=%h cout=%b v=%b want 0000 0 0",
               Sum, Cout, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    exp_sum  = 16'h0000;
    exp_cout = 1'b0;
    exp_v    = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] ta [5] = '{16'd22, 16'd35, 16'd243, 16'd645, 16'd7};
    logic [15:0] tb [5] = '{16'd53, 16'd42, 16'd37, 16'd246, 16'd6};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] want [5] = '{16'd75, 16'd78, 16'd280, 16'd891, 16'd14};
    for (int i = 0; i < 5; i++) begin
      step(ta[i], tb[i], tc[i], 1'b1);
      checks++;
      if (Sum !== want[i] || Cout !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_%0d: got sum=%0d cout=%b v=%b want %0d 0 1",
                 i, Sum, Cout, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_ripple;
    logic [15:0] ta [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0001, 16'hFFFF, 16'hFFFF};
    logic        tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] want [3] = '{16'h0000, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      step(ta[i], tb[i], tc[i], 1'b1);
      checks++;
      if (Sum !== want[i] || Cout !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ripple_%0d: got sum=%h cout=%b v=%b want %h 1 1",
                 i, Sum, Cout, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold;
    step(16'h1234, 16'h1111, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h2345 || Cout !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_load: got sum=%h cout=%b v=%b want 2345 0 1",
               Sum, Cout, out_valid);
    end
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    checks++;
    if (Sum !== 16'h2345 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got sum=%h cout=%b v=%b want 2345 0 0",
               Sum, Cout, out_valid);
    end
  endtask

  task automatic test_tree;
    logic [15:0] ta [4] = '{16'h00FF, 16'h0FFF, 16'h7FFF, 16'h8000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic [15:0] want [4] = '{16'h0100, 16'h1000, 16'h8000, 16'h0000};
    logic        wc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(ta[i], tb[i], 1'b0, 1'b1);
      checks++;
      if (Sum !== want[i] || Cout !== wc[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL tree_%0d: got sum=%h cout=%b v=%b want %h %b 1",
                 i, Sum, Cout, out_valid, want[i], wc[i]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    step(16'h4321, 16'h1111, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== 16'h0000 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sum=%h cout=%b v=%b want 0000 0 0",
               Sum, Cout, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    exp_sum  = 16'h0000;
    exp_cout = 1'b0;
    exp_v    = 1'b0;
    step(16'h0F0F, 16'hF0F1, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h0000 || Cout !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got sum=%h cout=%b v=%b want 0000 1 1",
               Sum, Cout, out_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10000; i++) begin
      step(16'($urandom), 16'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
      checks++;
      if (Sum !== exp_sum || Cout !== exp_cout || out_valid !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: got sum=%h cout=%b v=%b want %h %b %b",
                 i, Sum, Cout, out_valid, exp_sum, exp_cout, exp_v);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_hold();
    test_tree();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
